booth_mult_seq: RTL and testbench
=================================

# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier for two's-complement operands, with its controller and datapath in one block. An internal step counter replaces a fully unrolled state chain, so one FSM serves any operand width. It sits behind a start/done handshake and holds its product until the next operation starts. It is the drop-in generalised replacement for the fixed-width Booth controller/datapath pair.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  clock; all state changes on posedge clk.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a multiply; sampled only in IDLE.
- x_in  input  WIDTH  multiplier, signed; sampled in the cycle start is accepted.
- y_in  input  WIDTH  multiplicand, signed; sampled in the cycle start is accepted.
- busy  output  1  high from INIT through the last SHIFT.
- done  output  1  one-cycle pulse; product valid from this cycle on.
- product  output  2*WIDTH  signed result x_in*y_in; registered.

## Operation
- Internal registers:
  - A: WIDTH+1 bits, sign-extended accumulator. The extra bit makes A−Y exact for y = −2^(WIDTH−1).
  - X: WIDTH bits.
  - Y: WIDTH bits.
  - E: 1 bit, Booth Q−1.
  - cnt: ceil(log2(WIDTH)) bits.
- States: IDLE, INIT, EVAL, SHIFT, DONE.
- IDLE:
  - Outputs idle.
  - start=1 → INIT, and x_in/y_in are captured into X/Y in the same edge.
- INIT: A←0, E←0, cnt←0 → EVAL.
- EVAL, decoded on {X[0],E}:
  - 10: A←A−sext(Y).
  - 01: A←A+sext(Y).
  - 00 or 11: A unchanged.
  - Always → SHIFT.
- SHIFT:
  - Arithmetic right shift of {A,X,E} by one, with A's MSB replicated.
  - cnt←cnt+1.
  - If cnt==WIDTH−1 (before increment) → DONE, else → EVAL.
- DONE:
  - product←{A[WIDTH−1:0],X}, loaded on entry, so it is visible in the DONE cycle.
  - done=1 for exactly one cycle → IDLE.
- product holds its value until the next DONE. It is not cleared by start.
- start while busy=1 or in DONE is ignored. No queueing.
- Result is exact for all signed operand pairs, including (−2^(W−1))·(−2^(W−1)) = 2^(2W−2).

## Timing
- Reset values: busy=0, done=0, product=0, state=IDLE. All internal registers are 0.
- rst has priority in any state. A mid-operation reset aborts and returns to IDLE in the next cycle. No done pulse follows.
- Latency, counting the start-accept cycle as cycle 0:
  - INIT in cycle 1.
  - EVAL/SHIFT pairs in cycles 2..2W+1.
  - DONE (done=1) in cycle 2W+2.
- busy is high in cycles 1..2W+1. It is low in DONE and in IDLE.
- A new start is accepted in the cycle after DONE at the earliest. Back-to-back throughput is one result per 2W+3 cycles.
- Inputs only need to be stable in the start-accept cycle.

## Configuration
- Macro BOOTH_SKIP_EN.
- Undefined: fixed latency as above, with every bit taking EVAL then SHIFT.
- Defined:
  - In EVAL, a pair of 00 or 11 performs the SHIFT action directly, including the cnt update and exit check. The FSM then goes to EVAL or DONE, skipping the SHIFT state.
  - Latency becomes 2W+2 − k, where k is the number of 00/11 pairs examined.
  - Results are identical. busy still covers every cycle from INIT up to DONE.

## Test plan
- WIDTH=8, x=3, y=5, start pulse → product=0x000F, done in cycle 18, busy high in cycles 1..17.
- x=−128, y=−128 → product=0x4000. Also x=−7, y=6 → product=0xFFD6 (−42). Also x=127, y=−128 → 0xC080.
- Raise start again in cycles 3 and 18 of a running op → both ignored; the single done matches the first operands. product holds until the next DONE.
- Assert rst in cycle 7 of an operation → busy=0, done=0, product=0 next cycle. A following op with x=2, y=2 → 0x0004.
- BOOTH_SKIP_EN defined:
  - x=0, y=99 → product=0, done in cycle 10.
  - x=0x55, y=1 → all pairs are 10/01, done in cycle 18, product=0x0055.
- Random signed sweep for WIDTH ∈ {2,5,8,16}, with and without the macro → product equals the reference product. Measured latency equals the formula.

Source files
------------

// File: rtl/booth_mult_seq_if.sv
// booth_mult_seq_if
//   Start/done handshake and operand/result bus for booth_mult_seq.
//   Parameter WIDTH : operand width in bits (must match the multiplier).
//   Signals:
//     start   - request a multiply (driven by master)
//     x_in    - signed multiplier operand (driven by master)
//     y_in    - signed multiplicand operand (driven by master)
//     busy    - operation in progress (driven by slave)
//     done    - one-cycle completion pulse (driven by slave)
//     product - registered signed product, 2*WIDTH bits (driven by slave)
//   Modports: master (requester side), slave (multiplier side).
interface booth_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     x_in;
  logic [WIDTH-1:0]     y_in;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, x_in, y_in,
    input  busy, done, product
  );

  modport slave (
    input  start, x_in, y_in,
    output busy, done, product
  );
endinterface

// File: rtl/booth_mult_seq.sv
// booth_mult_seq
//   Sequential radix-2 Booth multiplier for two's-complement operands.
//   A step counter walks the multiplier bits so one FSM (IDLE, INIT, EVAL,
//   SHIFT, DONE) serves any operand width. The product register holds its
//   value until the next completed operation.
//   Parameter WIDTH : operand width, 2..32.
//   Ports:
//     clk  - clock, all state changes on the rising edge
//     rst  - synchronous active-high reset, priority over everything
//     bus  - booth_mult_seq_if.slave (start, x_in, y_in, busy, done, product)
//   Optional feature macro: BOOTH_SKIP_EN
//     When defined, an EVAL step that sees a 00/11 Booth pair performs the
//     shift directly and skips the SHIFT state. Results are unchanged.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  booth_mult_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  // One guard bit above WIDTH keeps A - Y exact when Y is the most
  // negative value.
  logic [WIDTH:0]       a_reg, a_next;
  logic [WIDTH-1:0]     x_reg, x_next;
  logic [WIDTH-1:0]     y_reg, y_next;
  logic                 e_reg, e_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [2*WIDTH-1:0]   product_reg, product_next;

  logic [WIDTH:0]       y_sext;
  logic [WIDTH:0]       a_sh;
  logic [WIDTH-1:0]     x_sh;
  logic                 e_sh;
  logic                 last_step;
  logic                 do_shift;

  assign y_sext    = {y_reg[WIDTH-1], y_reg};
  assign last_step = (cnt_reg == CW'(WIDTH - 1));

  // Arithmetic right shift of the concatenation {A, X, E} by one bit.
  assign a_sh = {a_reg[WIDTH], a_reg[WIDTH:1]};
  assign e_sh = x_reg[0];
  assign x_sh[WIDTH-1] = a_reg[0];
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_x_shift
      assign x_sh[gi] = x_reg[gi + 1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      e_reg       <= 1'b0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      e_reg       <= e_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    e_next       = e_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;
    do_shift     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          x_next     = bus.x_in;
          y_next     = bus.y_in;
          state_next = INIT;
        end
      end
      INIT: begin
        a_next     = '0;
        e_next     = 1'b0;
        cnt_next   = '0;
        state_next = EVAL;
      end
      EVAL: begin
        case ({x_reg[0], e_reg})
          2'b10: begin
            a_next     = a_reg - y_sext;
            state_next = SHIFT;
          end
          2'b01: begin
            a_next     = a_reg + y_sext;
            state_next = SHIFT;
          end
          default: begin
`ifdef BOOTH_SKIP_EN
            // Nothing to add: fold the shift into this cycle.
            do_shift = 1'b1;
`else
            state_next = SHIFT;
`endif
          end
        endcase
      end
      SHIFT: begin
        do_shift = 1'b1;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Shared shift step: used by SHIFT and, when skipping, by EVAL.
    if (do_shift) begin
      a_next   = a_sh;
      x_next   = x_sh;
      e_next   = e_sh;
      cnt_next = cnt_reg + CW'(1);
      if (last_step) begin
        // Load the result on the way into DONE so it is visible there.
        product_next = {a_sh[WIDTH-1:0], x_sh};
        state_next   = DONE;
      end else begin
        state_next = EVAL;
      end
    end
  end

  assign bus.busy    = (state_reg == INIT) || (state_reg == EVAL) ||
                       (state_reg == SHIFT);
  assign bus.done    = (state_reg == DONE);
  assign bus.product = product_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq
//   Directed and randomised checks of booth_mult_seq at WIDTH=8: reset state,
//   products, done latency and busy window, ignored starts, product hold,
//   mid-operation reset, and the BOOTH_SKIP_EN latency cases.
module tb_booth_mult_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_mult_seq_if #(.WIDTH(W)) bus ();
  booth_mult_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Cycle in which done is expected, counting the accept cycle as 0.
  function automatic int exp_lat(input logic [W-1:0] x);
    int k;
    logic prev;
    k = 0;
    prev = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (x[i] == prev) k++;
      prev = x[i];
    end
`ifdef BOOTH_SKIP_EN
    return 2*W + 2 - k;
`else
    return 2*W + 2 + 0*k;
`endif
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  // Launch one operation; optionally re-raise start (with other operands)
  // in cycles extra1/extra2. Operand inputs are scrambled after the accept
  // cycle to show they are only needed there.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input int extra1, input int extra2,
                        output logic [2*W-1:0] prod,
                        output logic [2*W-1:0] prod_c2,
                        output int done_cyc, output int busy_err);
    int c;
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = x;
    bus.y_in  = y;
    c = 0;
    done_cyc = -1;
    busy_err = 0;
    prod = '0;
    prod_c2 = '0;
    while (done_cyc < 0 && c < 200) begin
      @(negedge clk);
      c++;
      if (c == extra1 || c == extra2) begin
        bus.start = 1'b1;
        bus.x_in  = 8'h7f;
        bus.y_in  = 8'h7f;
      end else begin
        bus.start = 1'b0;
        bus.x_in  = ~x;
        bus.y_in  = ~y;
      end
      if (c == 2) prod_c2 = bus.product;
      if (bus.done) begin
        done_cyc = c;
        prod = bus.product;
        if (bus.busy) busy_err++;
      end else if (!bus.busy) begin
        busy_err++;
      end
    end
    $display("op x=%0d y=%0d product=0x%h done_cycle=%0d busy_errors=%0d",
             $signed(x), $signed(y), prod, done_cyc, busy_err);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.x_in = '0;
    bus.y_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy);
    else n_pass++;
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL reset_done got=%b want=0", bus.done);
    else n_pass++;
    n_checks++;
    if (bus.product !== 16'h0000) $display("FAIL reset_product got=0x%h want=0x0000", bus.product);
    else n_pass++;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_products;
    logic [W-1:0]   xv [4];
    logic [W-1:0]   yv [4];
    logic [2*W-1:0] pv [4];
    logic [2*W-1:0] p, p2;
    int dc, be;
    xv[0] = 8'd3;   yv[0] = 8'd5;   pv[0] = 16'h000F;
    xv[1] = 8'h80;  yv[1] = 8'h80;  pv[1] = 16'h4000;
    xv[2] = 8'hF9;  yv[2] = 8'd6;   pv[2] = 16'hFFD6;
    xv[3] = 8'h7F;  yv[3] = 8'h80;  pv[3] = 16'hC080;
    for (int i = 0; i < 4; i++) begin
      run_op(xv[i], yv[i], -1, -1, p, p2, dc, be);
      n_checks++;
      if (p !== pv[i]) $display("FAIL product_%0d got=0x%h want=0x%h", i, p, pv[i]);
      else n_pass++;
      n_checks++;
      if (dc !== exp_lat(xv[i])) $display("FAIL latency_%0d got=%0d want=%0d", i, dc, exp_lat(xv[i]));
      else n_pass++;
      n_checks++;
      if (be !== 0) $display("FAIL busy_window_%0d got=%0d want=0", i, be);
      else n_pass++;
      idle(1);
    end
  endtask

  task automatic test_ignored_start;
    logic [2*W-1:0] p, p2;
    int dc, be, lat, hold_err;
    lat = exp_lat(8'd9);
    run_op(8'd9, 8'hFD, 3, lat, p, p2, dc, be);
    n_checks++;
    if (p !== 16'hFFE5) $display("FAIL ignored_product got=0x%h want=0xffe5", p);
    else n_pass++;
    n_checks++;
    if (dc !== lat) $display("FAIL ignored_latency got=%0d want=%0d", dc, lat);
    else n_pass++;
    idle(1);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL ignored_after_done_busy got=%b want=0", bus.busy);
    else n_pass++;
    idle(1);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL ignored_no_restart got=busy%b/done%b want=busy0/done0", bus.busy, bus.done);
    else n_pass++;
    hold_err = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (bus.product !== 16'hFFE5) hold_err++;
    end
    n_checks++;
    if (hold_err !== 0) $display("FAIL product_hold got=%0d_changes want=0", hold_err);
    else n_pass++;
    run_op(8'd2, 8'd3, -1, -1, p, p2, dc, be);
    n_checks++;
    if (p2 !== 16'hFFE5) $display("FAIL product_kept_on_start got=0x%h want=0xffe5", p2);
    else n_pass++;
    n_checks++;
    if (p !== 16'h0006) $display("FAIL product_after_hold got=0x%h want=0x0006", p);
    else n_pass++;
    idle(1);
  endtask

  task automatic test_reset_mid;
    logic [2*W-1:0] p, p2;
    int dc, be, spurious;
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_in = 8'd5;
    bus.y_in = 8'd9;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 7) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    $display("op mid-reset busy=%b done=%b product=0x%h", bus.busy, bus.done, bus.product);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL midreset_busy got=%b want=0", bus.busy);
    else n_pass++;
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL midreset_done got=%b want=0", bus.done);
    else n_pass++;
    n_checks++;
    if (bus.product !== 16'h0000) $display("FAIL midreset_product got=0x%h want=0x0000", bus.product);
    else n_pass++;
    spurious = 0;
    for (int i = 0; i < 25; i++) begin
      idle(1);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious !== 0) $display("FAIL midreset_no_done got=%0d want=0", spurious);
    else n_pass++;
    run_op(8'd2, 8'd2, -1, -1, p, p2, dc, be);
    n_checks++;
    if (p !== 16'h0004) $display("FAIL after_reset_product got=0x%h want=0x0004", p);
    else n_pass++;
    n_checks++;
    if (dc !== exp_lat(8'd2)) $display("FAIL after_reset_latency got=%0d want=%0d", dc, exp_lat(8'd2));
    else n_pass++;
    idle(1);
  endtask

  task automatic test_skip;
    logic [2*W-1:0] p, p2;
    int dc, be, want0, want55;
`ifdef BOOTH_SKIP_EN
    want0 = 10;
`else
    want0 = 18;
`endif
    want55 = 18;
    run_op(8'd0, 8'd99, -1, -1, p, p2, dc, be);
    n_checks++;
    if (p !== 16'h0000) $display("FAIL skip_zero_product got=0x%h want=0x0000", p);
    else n_pass++;
    n_checks++;
    if (dc !== want0) $display("FAIL skip_zero_latency got=%0d want=%0d", dc, want0);
    else n_pass++;
    n_checks++;
    if (be !== 0) $display("FAIL skip_zero_busy got=%0d want=0", be);
    else n_pass++;
    idle(1);
    run_op(8'h55, 8'd1, -1, -1, p, p2, dc, be);
    n_checks++;
    if (p !== 16'h0055) $display("FAIL skip_alt_product got=0x%h want=0x0055", p);
    else n_pass++;
    n_checks++;
    if (dc !== want55) $display("FAIL skip_alt_latency got=%0d want=%0d", dc, want55);
    else n_pass++;
    idle(1);
  endtask

  task automatic test_random;
    logic signed [W-1:0]   xs, ys;
    logic signed [2*W-1:0] xe, ye, ref_p;
    logic [2*W-1:0] p, p2;
    int dc, be;
    for (int i = 0; i < 20; i++) begin
      xs = W'($urandom);
      ys = W'($urandom);
      xe = xs;
      ye = ys;
      ref_p = xe * ye;
      run_op(xs, ys, -1, -1, p, p2, dc, be);
      n_checks++;
      if (p !== ref_p) $display("FAIL rand_product_%0d got=0x%h want=0x%h", i, p, ref_p);
      else n_pass++;
      n_checks++;
      if (dc !== exp_lat(xs)) $display("FAIL rand_latency_%0d got=%0d want=%0d", i, dc, exp_lat(xs));
      else n_pass++;
      idle(1);
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_ignored_start();
    test_reset_mid();
    test_skip();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
